// File: rtl/md_sequencer.sv
// md_sequencer: HI/LO multiply/divide sequencer for E; owns architectural HI/LO. Optional feature macro: MD_ROLLBACK_EN.
// Latency: mult/multu commit MULT_LAT cycles after accept, div/divu DIV_LAT cycles; mthi/mtlo visible the next cycle.
// Backpressure: busy while a mult/div is in flight; stall holds D when a HI/LO op in D meets a busy or issuing unit.
module md_sequencer #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        int_req,
    input  logic        rollback,
    input  logic        d_md,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    // cnt is loaded with LAT-1 so RUN lasts exactly LAT cycles
    localparam logic [3:0] MULT_CNT = 4'(MULT_LAT - 1);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT - 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] ph;
    logic [31:0] pl;
    logic        pend_wr;

    // Issue qualification
    logic op_md;
    logic op_mt;
    logic op_div;
    logic issue_ok;
    logic accept_md;
    logic accept_mt;

    assign op_md     = (op >= OP_MULT) && (op <= OP_DIVU);
    assign op_mt     = (op == OP_MTHI) || (op == OP_MTLO);
    assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign issue_ok  = start & ~int_req & (state == IDLE);
    assign accept_md = issue_ok & op_md;
    assign accept_mt = issue_ok & op_mt;

    // A mult/div being accepted this cycle already blocks the D-stage HI/LO op
    assign stall = d_md & (busy | accept_md);

    // Arithmetic, all evaluated in the accept cycle
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_zero;
    logic [31:0] u_den;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [31:0] s_den;
    logic [31:0] mq;
    logic [31:0] mr;
    logic [31:0] sq;
    logic [31:0] sr;

    assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // A zero divisor is replaced by 1 only to keep the dividers well defined; its result is never committed
    assign div_zero = (rt_val == 32'd0);
    assign u_den    = div_zero ? 32'd1 : rt_val;
    assign uq       = rs_val / u_den;
    assign ur       = rs_val % u_den;

    // Signed divide via magnitudes: 0x80000000 / -1 falls out as LO=0x80000000, HI=0 with no trap case
    assign rs_mag = rs_val[31] ? (32'd0 - rs_val) : rs_val;
    assign rt_mag = rt_val[31] ? (32'd0 - rt_val) : rt_val;
    assign s_den  = div_zero ? 32'd1 : rt_mag;
    assign mq     = rs_mag / s_den;
    assign mr     = rs_mag % s_den;
    assign sq     = (rs_val[31] ^ rt_val[31]) ? (32'd0 - mq) : mq;
    assign sr     = rs_val[31] ? (32'd0 - mr) : mr;

    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic [3:0]  res_cnt;

    // Select the pending result and RUN length for the op being issued
    always_comb begin
        res_hi  = 32'd0;
        res_lo  = 32'd0;
        res_cnt = op_div ? DIV_CNT : MULT_CNT;
        case (op)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV: begin
                res_hi = sr;
                res_lo = sq;
            end
            OP_DIVU: begin
                res_hi = ur;
                res_lo = uq;
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
            end
        endcase
    end

`ifdef MD_ROLLBACK_EN
    logic [31:0] bk_hi;
    logic [31:0] bk_lo;
    logic        just_issued;
    logic        do_rb;

    // Only the op issued in the previous cycle can still be in M and be undone
    assign do_rb = rollback & just_issued;
`else
    logic unused_rollback;
    assign unused_rollback = rollback;
`endif

    // Sequencer FSM: issue, count down, commit; optional undo of the just-issued op
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            ph      <= 32'd0;
            pl      <= 32'd0;
            pend_wr <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            busy    <= 1'b0;
`ifdef MD_ROLLBACK_EN
            bk_hi       <= 32'd0;
            bk_lo       <= 32'd0;
            just_issued <= 1'b0;
`endif
        end else begin
`ifdef MD_ROLLBACK_EN
            just_issued <= (accept_md | accept_mt) & ~do_rb;
            if (do_rb) begin
                hi      <= bk_hi;
                lo      <= bk_lo;
                pend_wr <= 1'b0;
                state   <= IDLE;
                cnt     <= 4'd0;
                busy    <= 1'b0;
            end else begin
                if (accept_md | accept_mt) begin
                    bk_hi <= hi;
                    bk_lo <= lo;
                end
`else
            begin
`endif
                case (state)
                    IDLE: begin
                        if (accept_md) begin
                            ph      <= res_hi;
                            pl      <= res_lo;
                            pend_wr <= ~(op_div & div_zero);
                            cnt     <= res_cnt;
                            state   <= RUN;
                            busy    <= 1'b1;
                        end else if (accept_mt) begin
                            if (op == OP_MTHI) begin
                                hi <= rs_val;
                            end else begin
                                lo <= rs_val;
                            end
                        end
                    end
                    RUN: begin
                        if (cnt != 4'd0) begin
                            cnt <= cnt - 4'd1;
                        end else begin
                            if (pend_wr) begin
                                hi <= ph;
                                lo <= pl;
                            end
                            pend_wr <= 1'b0;
                            state   <= IDLE;
                            busy    <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
